// File: rtl/time_pkg.sv
// Shared time constants and the seconds-of-day decoder state encoding.
package time_pkg;

    localparam int unsigned SECONDS_PER_HOUR   = 3600;
    localparam int unsigned SECONDS_PER_MINUTE = 60;
    localparam int unsigned HOURS_PER_DAY      = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HRS    = 2'd1,
        MINS   = 2'd2,
        DIGITS = 2'd3
    } dec_state_t;

endpackage

// File: rtl/bcd_split_6.sv
// Combinational split of a 6-bit binary value (0..59) into BCD tens/units.
module bcd_split_6 (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [5:0] tens_x10;

    always_comb begin
        tens = '0;
        if      (bin >= 6'd50) tens = 4'd5;
        else if (bin >= 6'd40) tens = 4'd4;
        else if (bin >= 6'd30) tens = 4'd3;
        else if (bin >= 6'd20) tens = 4'd2;
        else if (bin >= 6'd10) tens = 4'd1;
        tens_x10 = 6'(tens) * 6'd10;
        units    = 4'(bin - tens_x10);
    end

endmodule

// File: rtl/time_count_decoder.sv
// Seconds-of-day to HH:MM:SS BCD converter using repeated subtraction.
// Define TIME_COUNT_DECODER_12H_EN for 12-hour display with PM flag.
module time_count_decoder
    import time_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 17,
    parameter int unsigned MAX_COUNT = 86400
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic [BIT_WIDTH-1:0] i_Count,
    input  logic                 i_Count_Valid,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_Error,
    output logic [3:0]           o_Hours_Tens,
    output logic [3:0]           o_Hours_Units,
    output logic [3:0]           o_Minutes_Tens,
    output logic [3:0]           o_Minutes_Units,
    output logic [3:0]           o_Seconds_Tens,
    output logic [3:0]           o_Seconds_Units,
    output logic                 o_PM
);

    dec_state_t           state, next_state;
    logic [BIT_WIDTH-1:0] remainder;
    logic [4:0]           hours;
    logic [5:0]           minutes;
    logic                 err_pend;

    logic                 accept;
    logic                 count_bad;
    logic                 hr_ge;
    logic                 min_ge;

    logic [4:0]           disp_hours;
    logic                 pm_next;
    logic [3:0]           ht, hu, mt, mu, st, su;

    assign accept    = (state == IDLE) && i_Count_Valid && !err_pend;
    assign count_bad = 32'(i_Count) >= MAX_COUNT;
    assign hr_ge     = 32'(remainder) >= SECONDS_PER_HOUR;
    assign min_ge    = 32'(remainder) >= SECONDS_PER_MINUTE;
    assign o_Busy    = (state != IDLE);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && !count_bad) next_state = HRS;
            HRS:     if (!hr_ge)               next_state = MINS;
            MINS:    if (!min_ge)              next_state = DIGITS;
            DIGITS:                            next_state = IDLE;
            default:                           next_state = IDLE;
        endcase
    end

`ifdef TIME_COUNT_DECODER_12H_EN
    localparam logic [4:0] HALF_DAY = 5'(HOURS_PER_DAY / 2);

    always_comb begin
        disp_hours = hours;
        if (hours == 5'd0)          disp_hours = HALF_DAY;
        else if (hours > HALF_DAY)  disp_hours = hours - HALF_DAY;
    end
    assign pm_next = (hours >= HALF_DAY);
`else
    assign disp_hours = hours;
    assign pm_next    = 1'b0;
`endif

    bcd_split_6 u_split_hours (
        .bin   ({1'b0, disp_hours}),
        .tens  (ht),
        .units (hu)
    );

    bcd_split_6 u_split_minutes (
        .bin   (minutes),
        .tens  (mt),
        .units (mu)
    );

    bcd_split_6 u_split_seconds (
        .bin   (remainder[5:0]),
        .tens  (st),
        .units (su)
    );

    // An out-of-range count is flagged one edge after acceptance while the FSM stays in IDLE.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            remainder       <= '0;
            hours           <= '0;
            minutes         <= '0;
            err_pend        <= 1'b0;
            o_Done          <= 1'b0;
            o_Error         <= 1'b0;
            o_PM            <= 1'b0;
            o_Hours_Tens    <= '0;
            o_Hours_Units   <= '0;
            o_Minutes_Tens  <= '0;
            o_Minutes_Units <= '0;
            o_Seconds_Tens  <= '0;
            o_Seconds_Units <= '0;
        end else begin
            o_Done   <= 1'b0;
            err_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (err_pend) begin
                        o_Done  <= 1'b1;
                        o_Error <= 1'b1;
                    end
                    if (accept) begin
                        remainder <= i_Count;
                        hours     <= '0;
                        minutes   <= '0;
                        if (count_bad) err_pend <= 1'b1;
                        else           o_Error  <= 1'b0;
                    end
                end
                HRS: begin
                    if (hr_ge) begin
                        remainder <= remainder - BIT_WIDTH'(SECONDS_PER_HOUR);
                        hours     <= hours + 5'd1;
                    end
                end
                MINS: begin
                    if (min_ge) begin
                        remainder <= remainder - BIT_WIDTH'(SECONDS_PER_MINUTE);
                        minutes   <= minutes + 6'd1;
                    end
                end
                DIGITS: begin
                    o_Hours_Tens    <= ht;
                    o_Hours_Units   <= hu;
                    o_Minutes_Tens  <= mt;
                    o_Minutes_Units <= mu;
                    o_Seconds_Tens  <= st;
                    o_Seconds_Units <= su;
                    o_PM            <= pm_next;
                    o_Done          <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_time_count_decoder.sv
// Directed self-checking bench for time_count_decoder (24h and 12h builds).
module tb_time_count_decoder;

`ifdef TIME_COUNT_DECODER_12H_EN
    localparam bit H12 = 1'b1;
`else
    localparam bit H12 = 1'b0;
`endif

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic [16:0] i_Count;
    logic        i_Count_Valid;
    logic        o_Busy, o_Done, o_Error, o_PM;
    logic [3:0]  o_Hours_Tens, o_Hours_Units;
    logic [3:0]  o_Minutes_Tens, o_Minutes_Units;
    logic [3:0]  o_Seconds_Tens, o_Seconds_Units;

    int checks = 0;
    int errors = 0;

    time_count_decoder #(.BIT_WIDTH(17), .MAX_COUNT(86400)) dut (
        .i_Clk           (i_Clk),
        .i_Reset         (i_Reset),
        .i_Count         (i_Count),
        .i_Count_Valid   (i_Count_Valid),
        .o_Busy          (o_Busy),
        .o_Done          (o_Done),
        .o_Error         (o_Error),
        .o_Hours_Tens    (o_Hours_Tens),
        .o_Hours_Units   (o_Hours_Units),
        .o_Minutes_Tens  (o_Minutes_Tens),
        .o_Minutes_Units (o_Minutes_Units),
        .o_Seconds_Tens  (o_Seconds_Tens),
        .o_Seconds_Units (o_Seconds_Units),
        .o_PM            (o_PM)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [23:0] digits();
        return {o_Hours_Tens, o_Hours_Units, o_Minutes_Tens,
                o_Minutes_Units, o_Seconds_Tens, o_Seconds_Units};
    endfunction

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse valid for one edge, wait for o_Done, then check latency, busy, digits and flags.
    task automatic convert(input string tag, input int unsigned count, input int unsigned lat,
                           input bit exp_busy, input logic [23:0] exp_dig,
                           input bit exp_pm, input bit exp_err);
        int unsigned cycles;
        bit busy_ok;
        i_Count       = 17'(count);
        i_Count_Valid = 1'b1;
        tick();
        i_Count_Valid = 1'b0;
        cycles  = 0;
        busy_ok = 1'b1;
        while (o_Done !== 1'b1 && cycles < 200) begin
            if (o_Busy !== exp_busy) busy_ok = 1'b0;
            tick();
            cycles++;
        end
        chk({tag, "_latency"}, cycles, lat);
        chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(o_Busy), 32'd0);
        chk({tag, "_digits"}, 32'(digits()), 32'(exp_dig));
        chk({tag, "_pm"}, 32'(o_PM), 32'(exp_pm));
        chk({tag, "_error"}, 32'(o_Error), 32'(exp_err));
        tick();
        chk({tag, "_done_pulse"}, 32'(o_Done), 32'd0);
    endtask

    initial begin
        int unsigned cycles;
        int unsigned extra_done;

        i_Reset       = 1'b1;
        i_Count       = '0;
        i_Count_Valid = 1'b0;
        tick();
        tick();
        chk("reset_digits", 32'(digits()), 32'd0);
        chk("reset_flags", {28'd0, o_Busy, o_Done, o_Error, o_PM}, 32'd0);
        i_Reset = 1'b0;
        tick();

        convert("c0", 0, 3, 1'b1, H12 ? 24'h120000 : 24'h000000, 1'b0, 1'b0);
        convert("c3661", 3661, 5, 1'b1, 24'h010101, 1'b0, 1'b0);
        convert("c86399", 86399, 85, 1'b1, H12 ? 24'h115959 : 24'h235959, H12, 1'b0);

        // Out of range: digits and PM hold the previous result.
        convert("c86400", 86400, 1, 1'b0, H12 ? 24'h115959 : 24'h235959, H12, 1'b1);
        convert("c45296", 45296, 49, 1'b1, 24'h123456, H12, 1'b0);

        // Second valid mid-conversion must be ignored.
        i_Count       = 17'd45296;
        i_Count_Valid = 1'b1;
        tick();
        i_Count_Valid = 1'b0;
        cycles = 0;
        repeat (4) begin tick(); cycles++; end
        i_Count       = 17'd0;
        i_Count_Valid = 1'b1;
        tick();
        cycles++;
        i_Count_Valid = 1'b0;
        while (o_Done !== 1'b1 && cycles < 200) begin tick(); cycles++; end
        chk("mid_latency", cycles, 49);
        chk("mid_digits", 32'(digits()), 32'h123456);
        extra_done = 0;
        repeat (60) begin tick(); if (o_Done === 1'b1) extra_done++; end
        chk("mid_single_done", extra_done, 0);

        // Asynchronous reset during HRS of a long conversion.
        i_Count       = 17'd86399;
        i_Count_Valid = 1'b1;
        tick();
        i_Count_Valid = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", 32'(o_Busy), 32'd1);
        #2 i_Reset = 1'b1;
        #1;
        chk("async_rst_digits", 32'(digits()), 32'd0);
        chk("async_rst_flags", {28'd0, o_Busy, o_Done, o_Error, o_PM}, 32'd0);
        tick();
        i_Reset = 1'b0;
        extra_done = 0;
        repeat (100) begin tick(); if (o_Done === 1'b1) extra_done++; end
        chk("rst_no_done", extra_done, 0);
        chk("rst_idle", 32'(o_Busy), 32'd0);

        convert("c60", 60, 4, 1'b1, H12 ? 24'h120100 : 24'h000100, 1'b0, 1'b0);
        convert("c46800", 46800, 16, 1'b1, H12 ? 24'h010000 : 24'h130000, H12, 1'b0);
        convert("c43200", 43200, 15, 1'b1, 24'h120000, H12, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_count_decoder.md
# time_count_decoder

Sequential converter from the seconds-of-day count produced by the time counter into six BCD display digits (HH:MM:SS). Sits between the time counter and the seven-segment/display driver. It accepts a count on a single-cycle valid strobe, derives hours and minutes by repeated subtraction, and presents registered digits with a one-cycle done pulse.

## Interface
Parameters:
- BIT_WIDTH, 17, width of the incoming count.
- MAX_COUNT, 86400, number of legal counts; legal range is 0..MAX_COUNT-1.

Ports (one clock; reset is asynchronous and active-high):
- i_Clk  in  1  system clock, rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Count  in  BIT_WIDTH  seconds since midnight.
- i_Count_Valid  in  1  load strobe, sampled only in IDLE.
- o_Busy  out  1  high in every state except IDLE.
- o_Done  out  1  one-cycle pulse when digits or error are updated.
- o_Error  out  1  registered; set when the last accepted count was >= MAX_COUNT.
- o_Hours_Tens, o_Hours_Units  out  4 each  BCD hours.
- o_Minutes_Tens, o_Minutes_Units  out  4 each  BCD minutes.
- o_Seconds_Tens, o_Seconds_Units  out  4 each  BCD seconds.
- o_PM  out  1  PM indicator (12-hour build only, else 0).

## Operation
- States: IDLE, HRS, MINS, DIGITS.
- IDLE: on i_Count_Valid, capture remainder = i_Count and clear the hour/minute accumulators.
  - If i_Count >= MAX_COUNT: next edge pulses o_Done, sets o_Error and stays in IDLE; digits hold previous values.
  - Otherwise clear o_Error and go to HRS.
- HRS: if remainder >= 3600, subtract 3600 and increment hours (5 bits); else go to MINS.
- MINS: if remainder >= 60, subtract 60 and increment minutes (6 bits); else go to DIGITS. The remainder is now seconds (0..59).
- DIGITS: split hours, minutes and seconds into tens/units; register all digits and o_PM; pulse o_Done; return to IDLE.
- Arithmetic: remainder is BIT_WIDTH wide; all comparisons are unsigned; no value ever goes negative.
- i_Count_Valid outside IDLE is ignored. There is no queueing, and i_Count is not re-sampled.
- Reset at any time (including mid-conversion): state IDLE, all digits 0, o_Busy 0, o_Done 0, o_Error 0, o_PM 0.

## Timing
- Accept edge = edge 0. HRS takes H+1 edges and MINS takes M+1 edges, where H and M are the final hour and minute values. Outputs update and o_Done is high after edge H+M+3.
- Examples: latency 3 cycles for count 0; 85 cycles for 86399.
- Out-of-range count: o_Done high after edge 1; o_Busy stays 0.
- o_Busy rises after the accept edge and falls on the same edge that raises o_Done.
- A new valid is accepted in the cycle where o_Done is high (state is already IDLE).
- Digit outputs change only on o_Done edges or reset; they are stable between conversions.

## Configuration
- TIME_COUNT_DECODER_12H_EN defined:
  - Hours displayed 12-hour: 0 maps to 12, 13..23 maps to 1..11, 12 stays 12.
  - o_PM = (hours >= 12), registered with the digits.
- Undefined: hours displayed 0..23 and o_PM is tied 0.
- Latency is identical in both builds.

## Structure
- Shared package time_pkg holds:
  - SECONDS_PER_HOUR = 3600, SECONDS_PER_MINUTE = 60, HOURS_PER_DAY = 24.
  - The decoder state encoding (IDLE/HRS/MINS/DIGITS).
- One sub-module, bcd_split_6: combinational 6-bit binary (0..59) to tens/units BCD. It is instantiated three times in the DIGITS path (hours, minutes, seconds).

## Test plan
- Count 0 -> digits 00:00:00, o_Done after 3 cycles, o_Error 0. Count 3661 -> 01:01:01 after 5 cycles.
- Count 86399 -> 23:59:59, o_Done after 85 cycles; o_Busy high for exactly the preceding cycles.
- Count 86400 -> o_Done after 1 cycle, o_Error 1, digits unchanged from the prior conversion. Next legal count clears o_Error.
- Valid with 45296 accepted, second valid with 0 pulsed mid-conversion -> only 12:34:56 produced, a single o_Done.
- Reset asserted during HRS of a 86399 conversion -> all outputs 0 immediately; o_Done never pulses. Post-reset conversion of 60 -> 00:01:00.
- 12H build: count 0 -> 12:00:00 o_PM 0; 46800 -> 01:00:00 o_PM 1; 43200 -> 12:00:00 o_PM 1.
